// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: per-frame game sequencer for socially-distanced Pong.
// Holds ball, paddle and score state. The game advances once per video frame on
// frame_tick, so the renderer sees values that stay stable through active video.
//
// Ports
//   CLOCK_50    in   50 MHz clock, all state on rising edge
//   reset       in   asynchronous active-low reset
//   frame_tick  in   1-cycle pulse at start of vertical blank
//   start       in   1-cycle pulse, start/restart game (honoured in IDLE/GAMEOVER only)
//   l_up, l_dn  in   left paddle buttons, active-high
//   r_up, r_dn  in   right paddle buttons, active-high
//   ball_x/y    out  ball top-left column/row
//   paddle_l_y  out  left paddle top row
//   paddle_r_y  out  right paddle top row
//   score_l/r   out  scores, saturating at WIN_SCORE
//   state       out  game state (table below)
//
// Build option: define SPEEDUP_EN to speed the ball up by one px/frame every
// fourth paddle hit (capped at BALL_STEP_MAX); otherwise the step is fixed.
//
// state | meaning
// ------+----------------------------------------------------
//   0   | IDLE     waiting for start after reset
//   1   | SERVE    ball held centred for SERVE_FRAMES ticks
//   2   | PLAY     paddles and ball move every tick
//   3   | POINT    one-tick pause after a miss, ball frozen
//   4   | GAMEOVER a player reached WIN_SCORE, waiting for start
module pong_game_ctrl #(
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int PADDLE_H      = 64,
  parameter int PADDLE_W      = 8,
  parameter int PADDLE_XL     = 16,
  parameter int BALL_SIZE     = 8,
  parameter int PADDLE_STEP   = 4,
  parameter int BALL_STEP     = 2,
  parameter int BALL_STEP_MAX = 6,
  parameter int SERVE_FRAMES  = 60,
  parameter int WIN_SCORE     = 7
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       l_up,
  input  logic       l_dn,
  input  logic       r_up,
  input  logic       r_dn,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle_l_y,
  output logic [9:0] paddle_r_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [2:0] state
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SERVE    = 3'd1;
  localparam logic [2:0] ST_PLAY     = 3'd2;
  localparam logic [2:0] ST_POINT    = 3'd3;
  localparam logic [2:0] ST_GAMEOVER = 3'd4;

  localparam logic [9:0] BALL_X0      = 10'(H_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [9:0] BALL_Y0      = 10'(V_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [9:0] PADDLE_Y0    = 10'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [9:0] PADDLE_Y_MAX = 10'(V_ACTIVE - PADDLE_H);
  localparam logic [9:0] PSTEP        = 10'(PADDLE_STEP);
  localparam logic [9:0] BALL_Y_MAX   = 10'(V_ACTIVE - BALL_SIZE);
  // Ball x after bouncing off the inner face of each paddle.
  localparam logic [9:0] X_HIT_L      = 10'(PADDLE_XL + PADDLE_W);
  localparam logic [9:0] X_HIT_R      = 10'(H_ACTIVE - PADDLE_XL - PADDLE_W - BALL_SIZE);
  localparam logic signed [10:0] NX_HIT_L = 11'(PADDLE_XL + PADDLE_W);
  localparam logic signed [10:0] NX_HIT_R = 11'(H_ACTIVE - PADDLE_XL - PADDLE_W - BALL_SIZE);
  localparam logic signed [10:0] NX_MAX   = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic signed [10:0] NY_MAX   = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  localparam int CNT_W    = $clog2(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam int STEP_CAP = (BALL_STEP_MAX > BALL_STEP) ? BALL_STEP_MAX : BALL_STEP;
  localparam int STEP_W   = $clog2(STEP_CAP + 1);

  logic [CNT_W-1:0]  serve_cnt;
  logic [STEP_W-1:0] step;
  logic              dx_neg, dy_neg, lost_left;
  logic [9:0]        pl_nxt, pr_nxt;
  logic signed [10:0] step_s, nx, ny;
  logic [10:0]       ball_top, ball_bot;
  logic              hit_l, hit_r, miss_l, miss_r, start_ok, win;

  function automatic logic [9:0] paddle_next(input logic [9:0] p, input logic up,
                                             input logic dn);
    logic [9:0] r;
    r = p;
    if (up && !dn)      r = (p < PSTEP) ? 10'd0 : p - PSTEP;
    else if (dn && !up) r = (p > PADDLE_Y_MAX - PSTEP) ? PADDLE_Y_MAX : p + PSTEP;
    return r;
  endfunction

  // Paddles move first; the ball is tested against this frame's paddle rows.
  always_comb begin
    pl_nxt   = paddle_next(paddle_l_y, l_up, l_dn);
    pr_nxt   = paddle_next(paddle_r_y, r_up, r_dn);
    step_s   = signed'(11'(step));
    nx       = dx_neg ? signed'({1'b0, ball_x}) - step_s : signed'({1'b0, ball_x}) + step_s;
    ny       = dy_neg ? signed'({1'b0, ball_y}) - step_s : signed'({1'b0, ball_y}) + step_s;
    ball_top = {1'b0, ball_y};
    ball_bot = ball_top + 11'(BALL_SIZE);
    hit_l    = dx_neg && (nx <= NX_HIT_L) && (ball_bot > {1'b0, pl_nxt}) &&
               (ball_top < {1'b0, pl_nxt} + 11'(PADDLE_H));
    hit_r    = !dx_neg && (nx >= NX_HIT_R) && (ball_bot > {1'b0, pr_nxt}) &&
               (ball_top < {1'b0, pr_nxt} + 11'(PADDLE_H));
    miss_l   = nx[10];
    miss_r   = nx > NX_MAX;
  end

  assign start_ok = start && (state == ST_IDLE || state == ST_GAMEOVER);
  assign win      = (score_l == WIN) || (score_r == WIN);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ball_x     <= BALL_X0;
      ball_y     <= BALL_Y0;
      paddle_l_y <= PADDLE_Y0;
      paddle_r_y <= PADDLE_Y0;
      score_l    <= 4'd0;
      score_r    <= 4'd0;
      dx_neg     <= 1'b0;
      dy_neg     <= 1'b0;
      lost_left  <= 1'b0;
      serve_cnt  <= '0;
    end else if (start_ok) begin
      state     <= ST_SERVE;
      serve_cnt <= '0;
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      ball_x    <= BALL_X0;
      ball_y    <= BALL_Y0;
      dx_neg    <= 1'b0;
      dy_neg    <= 1'b0;
    end else if (frame_tick) begin
      case (state)
        ST_SERVE: begin
          paddle_l_y <= pl_nxt;
          paddle_r_y <= pr_nxt;
          if (serve_cnt == SERVE_LAST) state <= ST_PLAY;
          else serve_cnt <= serve_cnt + 1'b1;
        end
        ST_PLAY: begin
          paddle_l_y <= pl_nxt;
          paddle_r_y <= pr_nxt;
          if (hit_l || hit_r || !(miss_l || miss_r)) begin
            if (hit_l) begin
              ball_x <= X_HIT_L;
              dx_neg <= 1'b0;
            end else if (hit_r) begin
              ball_x <= X_HIT_R;
              dx_neg <= 1'b1;
            end else begin
              ball_x <= nx[9:0];
            end
            if (ny[10]) begin
              ball_y <= 10'd0;
              dy_neg <= 1'b0;
            end else if (ny > NY_MAX) begin
              ball_y <= BALL_Y_MAX;
              dy_neg <= 1'b1;
            end else begin
              ball_y <= ny[9:0];
            end
          end else begin
            // Miss: ball stays where it was for the POINT frame.
            state     <= ST_POINT;
            lost_left <= miss_l;
            if (miss_l) begin
              if (score_r != WIN) score_r <= score_r + 4'd1;
            end else begin
              if (score_l != WIN) score_l <= score_l + 4'd1;
            end
          end
        end
        ST_POINT: begin
          if (win) begin
            state <= ST_GAMEOVER;
          end else begin
            state     <= ST_SERVE;
            serve_cnt <= '0;
            ball_x    <= BALL_X0;
            ball_y    <= BALL_Y0;
            dx_neg    <= lost_left;   // serve toward the player who lost the point
            dy_neg    <= 1'b0;
          end
        end
        ST_IDLE, ST_GAMEOVER: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPEEDUP_EN
  logic [1:0] hit_cnt;
  logic       serve_init;

  assign serve_init = start_ok || (frame_tick && state == ST_POINT && !win);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      step    <= STEP_W'(BALL_STEP);
      hit_cnt <= 2'd0;
    end else if (serve_init) begin
      step    <= STEP_W'(BALL_STEP);
      hit_cnt <= 2'd0;
    end else if (frame_tick && state == ST_PLAY && (hit_l || hit_r)) begin
      hit_cnt <= hit_cnt + 2'd1;
      if (hit_cnt == 2'd3 && step < STEP_W'(STEP_CAP)) step <= step + 1'b1;
    end
  end
`else
  assign step = STEP_W'(BALL_STEP);
`endif

endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       l_up = 1'b0, l_dn = 1'b0, r_up = 1'b0, r_dn = 1'b0;
  logic [9:0] ball_x, ball_y, paddle_l_y, paddle_r_y;
  logic [3:0] score_l, score_r;
  logic [2:0] state;

  int total = 0;
  int bad = 0;
  logic cmp_en = 1'b0;

  always #5 CLOCK_50 = ~CLOCK_50;

  pong_game_ctrl dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .frame_tick(frame_tick), .start(start),
    .l_up(l_up), .l_dn(l_dn), .r_up(r_up), .r_dn(r_dn),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .score_l(score_l), .score_r(score_r), .state(state)
  );

  // Reference game model in plain integers: direction is +1/-1, positions are ints.
  typedef struct packed {
    int st; int bx; int by; int dx; int dy; int pl; int pr;
    int sl; int sr; int cnt; int step; int hits; int lost_left;
  } mstate_t;

  mstate_t m;

  function automatic int pmove(input int p, input logic up, input logic dn);
    if (up && !dn) return (p - 4 < 0) ? 0 : p - 4;
    if (dn && !up) return (p + 4 > 416) ? 416 : p + 4;
    return p;
  endfunction

  function automatic mstate_t model_reset();
    mstate_t r;
    r = '0;
    r.st = 0; r.bx = 316; r.by = 236; r.dx = 1; r.dy = 1;
    r.pl = 208; r.pr = 208; r.step = 2;
    return r;
  endfunction

  function automatic mstate_t serve_init(input mstate_t c);
    mstate_t n;
    n = c;
    n.st = 1; n.cnt = 0; n.bx = 316; n.by = 236; n.dy = 1; n.step = 2; n.hits = 0;
    return n;
  endfunction

  function automatic mstate_t model_next(input mstate_t c, input logic st, input logic tk,
                                         input logic lu, input logic ld,
                                         input logic ru, input logic rd);
    mstate_t n;
    int nx, ny;
    logic hit;
    n = c;
    if (st && (c.st == 0 || c.st == 4)) begin
      n = serve_init(c);
      n.sl = 0; n.sr = 0; n.dx = 1;
      return n;
    end
    if (!tk) return n;
    case (c.st)
      1: begin
        n.pl = pmove(c.pl, lu, ld);
        n.pr = pmove(c.pr, ru, rd);
        n.cnt = c.cnt + 1;
        if (n.cnt == 60) n.st = 2;
      end
      2: begin
        n.pl = pmove(c.pl, lu, ld);
        n.pr = pmove(c.pr, ru, rd);
        nx = c.bx + c.dx * c.step;
        ny = c.by + c.dy * c.step;
        hit = 1'b0;
        if (c.dx < 0 && nx <= 24 && c.by + 8 > n.pl && c.by < n.pl + 64) begin
          n.bx = 24; n.dx = 1; hit = 1'b1;
        end else if (c.dx > 0 && nx >= 608 && c.by + 8 > n.pr && c.by < n.pr + 64) begin
          n.bx = 608; n.dx = -1; hit = 1'b1;
        end else if (nx < 0) begin
          n.st = 3; n.lost_left = 1;
          if (c.sr < 7) n.sr = c.sr + 1;
          return n;
        end else if (nx > 632) begin
          n.st = 3; n.lost_left = 0;
          if (c.sl < 7) n.sl = c.sl + 1;
          return n;
        end else begin
          n.bx = nx;
        end
        if (ny < 0) begin n.by = 0; n.dy = 1; end
        else if (ny > 472) begin n.by = 472; n.dy = -1; end
        else n.by = ny;
`ifdef SPEEDUP_EN
        if (hit) begin
          n.hits = c.hits + 1;
          if (n.hits % 4 == 0 && n.step < 6) n.step = c.step + 1;
        end
`else
        if (hit) n.hits = c.hits + 1;
`endif
      end
      3: begin
        if (c.sl == 7 || c.sr == 7) n.st = 4;
        else begin
          n = serve_init(c);
          n.dx = c.lost_left ? -1 : 1;
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  always @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) m <= model_reset();
    else m <= model_next(m, start, frame_tick, l_up, l_dn, r_up, r_dn);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (reset && cmp_en) begin
        chk("cyc_ball_x", int'(ball_x), m.bx);
        chk("cyc_ball_y", int'(ball_y), m.by);
        chk("cyc_paddle_l", int'(paddle_l_y), m.pl);
        chk("cyc_paddle_r", int'(paddle_r_y), m.pr);
        chk("cyc_score_l", int'(score_l), m.sl);
        chk("cyc_score_r", int'(score_r), m.sr);
        chk("cyc_state", int'(state), m.st);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ball_x"}, int'(ball_x), 316);
    chk({tag, "_ball_y"}, int'(ball_y), 236);
    chk({tag, "_paddle_l"}, int'(paddle_l_y), 208);
    chk({tag, "_paddle_r"}, int'(paddle_r_y), 208);
    chk({tag, "_score_l"}, int'(score_l), 0);
    chk({tag, "_score_r"}, int'(score_r), 0);
    chk({tag, "_state"}, int'(state), 0);
  endtask

  // One frame: tick with buttons, then a quiet cycle that may carry a start pulse
  // (only while the game is in progress, where it must be ignored).
  task automatic do_tick(input logic lu, input logic ld, input logic ru, input logic rd,
                         input logic want_start);
    @(negedge CLOCK_50);
    l_up = lu; l_dn = ld; r_up = ru; r_dn = rd; frame_tick = 1'b1;
    @(negedge CLOCK_50);
    frame_tick = 1'b0; l_up = 1'b0; l_dn = 1'b0; r_up = 1'b0; r_dn = 1'b0;
    start = want_start && (m.st >= 1 && m.st <= 3);
    @(negedge CLOCK_50);
    start = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge CLOCK_50);
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
  endtask

  task automatic rand_frame(input bit allow_start);
    logic lu, ld, ru, rd;
    int ctr, tgt;
    ctr = m.pl + 32;
    tgt = m.by + 4;
    lu = ctr > tgt + 2;
    ld = ctr < tgt - 2;
    if ($urandom_range(0, 9) == 0) begin
      lu = 1'($urandom_range(0, 1));
      ld = 1'($urandom_range(0, 1));
    end
    ru = ($urandom_range(0, 2) == 0);
    rd = ($urandom_range(0, 2) == 0);
    do_tick(lu, ld, ru, rd, allow_start && ($urandom_range(0, 39) == 0));
  endtask

  initial begin
    bit seen_point;
    seen_point = 1'b0;

    repeat (3) @(negedge CLOCK_50);
    check_reset_vals("in_reset");
    reset = 1'b1;
    cmp_en = 1'b1;

    repeat (10) do_tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_reset_vals("idle_10");

    pulse_start();
    chk("start_state", int'(state), 1);

    repeat (52) do_tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("serve_paddle_l_top", int'(paddle_l_y), 0);
    chk("serve_ball_held", int'(ball_x), 316);
    chk("serve_state", int'(state), 1);

    repeat (8) do_tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("both_btn_hold", int'(paddle_l_y), 0);
    chk("play_after_60", int'(state), 2);

    do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("first_move_x", int'(ball_x), 318);
    chk("first_move_y", int'(ball_y), 238);

    for (int i = 0; i < 6000; i++) begin
      rand_frame(1'b1);
      if (!seen_point && state == 3'd3) begin
        seen_point = 1'b1;
        chk("first_point_sum", int'(score_l) + int'(score_r), 1);
        do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("point_to_serve", int'(state), 1);
        chk("point_center_x", int'(ball_x), 316);
        chk("point_center_y", int'(ball_y), 236);
      end
      if (m.st == 4) break;
    end
    chk("gameover_reached", int'(state), 4);
    chk("winner_at_7", int'(score_l == 4'd7 || score_r == 4'd7), 1);

    repeat (5) rand_frame(1'b0);
    chk("gameover_frozen", int'(state), 4);

    pulse_start();
    chk("restart_score_l", int'(score_l), 0);
    chk("restart_score_r", int'(score_r), 0);
    chk("restart_state", int'(state), 1);

    repeat (70) rand_frame(1'b1);
    chk("mid_play_state", int'(state), 2);

    @(negedge CLOCK_50);
    #2 reset = 1'b0;
    #1 check_reset_vals("async_reset");
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b1;
    repeat (5) rand_frame(1'b0);
    chk("post_reset_idle", int'(state), 0);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
